// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected compute stage: fixed-point
// widths, state encoding and the accumulator-to-result saturating shift.
package fc_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;
    localparam int CNT_W     = 12;
    localparam int PROD_W    = 2 * DATA_W;

    // Result range expressed at accumulator width for the clamp compare
    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sh00_0000_7FFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 40'shFF_FFFF_8000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Drop the fractional bits (floor) and clamp into the signed result range
    function automatic logic [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic [DATA_W-1:0]       res;
        shifted = acc >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            res = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            res = 16'h8000;
        end else begin
            res = shifted[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fc_sat_round.sv
// Combinational output conditioning: arithmetic shift, saturation and, when
// FC_RELU_EN is defined, a fused ReLU that forces negative results to zero.
// Kept separate so convolution output stages can reuse it.
module fc_sat_round
    import fc_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    output logic        [DATA_W-1:0] result
);

    logic [DATA_W-1:0] sat_s;

    // Saturate the accumulator, then optionally clip negatives
    always_comb begin
        sat_s = sat_shift(acc);
`ifdef FC_RELU_EN
        if (sat_s[DATA_W-1]) begin
            result = {DATA_W{1'b0}};
        end else begin
            result = sat_s;
        end
`else
        result = sat_s;
`endif
    end

endmodule

// File: rtl/fc_mac_core.sv
// Fully-connected MAC stage. Captures features, multiplies them against a
// row-major weight stream through a two-stage pipeline, optionally adds
// biases, then streams saturated results out on a valid/ready port.
// Optional build macro: FC_RELU_EN (ReLU fused into the output stage).
module fc_mac_core
    import fc_pkg::*;
#(
    parameter int MAX_CIN  = 2048,
    parameter int MAX_COUT = 2048
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cin,
    input  logic [CNT_W-1:0]  cout,
    input  logic              has_bias,
    input  logic              lif_start,
    input  logic              lw_start,
    input  logic              sof_start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              fc_dout_valid,
    input  logic              fc_dout_ready,
    output logic [DATA_W-1:0] fc_dout_data,
    output logic              busy,
    output logic              done
);

    localparam int FADDR_W = $clog2(MAX_CIN);
    localparam int AADDR_W = $clog2(MAX_COUT);
    localparam logic [CNT_W-1:0] CIN_LIM  = CNT_W'(MAX_CIN);
    localparam logic [CNT_W-1:0] COUT_LIM = CNT_W'(MAX_COUT);

    // Buffers (contents intentionally not reset)
    logic signed [DATA_W-1:0] feat_mem [0:MAX_CIN-1];
    logic signed [ACC_W-1:0]  acc_mem  [0:MAX_COUT-1];

    state_t                   state_r, next_state_s;
    logic [CNT_W-1:0]         cin_r, cout_r, i_r, o_r;
    logic                     has_bias_r;
    logic signed [PROD_W-1:0] prod_r;
    logic                     v1_r, last1_r;
    logic [AADDR_W-1:0]       o1_r;
    logic signed [ACC_W-1:0]  run_acc_r;
    logic                     dout_valid_r, done_r, busy_r;
    logic [DATA_W-1:0]        dout_data_r;

    logic [CNT_W-1:0]         cin_clamp_s, cout_clamp_s;
    logic                     feat_we_s, w_accept_s, w_last_s, zero_we_s;
    logic                     b_accept_s, out_load_s, out_xfer_s;
    logic signed [DATA_W-1:0] feat_rd_s;
    logic signed [ACC_W-1:0]  acc_rdata_s, prod_ext_s, bias_ext_s;
    logic                     acc_we_s;
    logic [AADDR_W-1:0]       acc_waddr_s;
    logic signed [ACC_W-1:0]  acc_wdata_s;
    logic [DATA_W-1:0]        sat_s;
    logic                     unused_s;

    assign unused_s     = ^in_data[31:DATA_W];
    assign cin_clamp_s  = (cin  > CIN_LIM)  ? CIN_LIM  : cin;
    assign cout_clamp_s = (cout > COUT_LIM) ? COUT_LIM : cout;

    // Per-phase word acceptance; words past the phase count are dropped
    assign feat_we_s  = (state_r == S_IF) && in_valid && (i_r < cin_r);
    assign w_accept_s = (state_r == S_W) && in_valid && (cin_r != 12'd0) && (o_r < cout_r);
    assign w_last_s   = (i_r == (cin_r - 12'd1));
    assign zero_we_s  = (state_r == S_W) && (cin_r == 12'd0) && (o_r < cout_r);
    assign b_accept_s = (state_r == S_B) && in_valid && (o_r < cout_r);
    assign out_load_s = (state_r == S_OUT) && !dout_valid_r && (o_r < cout_r);
    assign out_xfer_s = dout_valid_r && fc_dout_ready;

    assign feat_rd_s   = feat_mem[i_r[FADDR_W-1:0]];
    assign acc_rdata_s = acc_mem[o_r[AADDR_W-1:0]];
    assign prod_ext_s  = ACC_W'(prod_r);
    assign bias_ext_s  = ACC_W'($signed(in_data[DATA_W-1:0])) <<< FRAC_BITS;

    fc_sat_round u_sat (
        .acc    (acc_rdata_s),
        .result (sat_s)
    );

    // Next-state decode; start pulses are only honoured in idle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (lif_start) begin
                    next_state_s = S_IF;
                end else if (lw_start) begin
                    next_state_s = S_W;
                end else if (sof_start) begin
                    next_state_s = (cout_r == 12'd0) ? S_DONE : S_OUT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_IF: begin
                if (i_r == cin_r) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_W: begin
                if ((o_r == cout_r) && !v1_r) begin
                    next_state_s = has_bias_r ? S_B : S_DONE;
                end else begin
                    next_state_s = S_W;
                end
            end
            S_B: begin
                if (o_r == cout_r) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_B;
                end
            end
            S_OUT: begin
                if ((o_r == cout_r) && !dout_valid_r) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_OUT;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Channel counts and the feature/output index counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin_r      <= 12'd0;
            cout_r     <= 12'd0;
            has_bias_r <= 1'b0;
            i_r        <= 12'd0;
            o_r        <= 12'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (lif_start) begin
                        cin_r <= cin_clamp_s;
                        i_r   <= 12'd0;
                        o_r   <= 12'd0;
                    end else if (lw_start) begin
                        cin_r      <= cin_clamp_s;
                        cout_r     <= cout_clamp_s;
                        has_bias_r <= has_bias;
                        i_r        <= 12'd0;
                        o_r        <= 12'd0;
                    end else if (sof_start) begin
                        i_r <= 12'd0;
                        o_r <= 12'd0;
                    end
                end
                S_IF: begin
                    if (feat_we_s) begin
                        i_r <= i_r + 12'd1;
                    end
                end
                S_W: begin
                    if (next_state_s == S_B) begin
                        i_r <= 12'd0;
                        o_r <= 12'd0;
                    end else if (w_accept_s) begin
                        if (w_last_s) begin
                            i_r <= 12'd0;
                            o_r <= o_r + 12'd1;
                        end else begin
                            i_r <= i_r + 12'd1;
                        end
                    end else if (zero_we_s) begin
                        o_r <= o_r + 12'd1;
                    end
                end
                S_B: begin
                    if (b_accept_s) begin
                        o_r <= o_r + 12'd1;
                    end
                end
                S_OUT: begin
                    if (out_xfer_s) begin
                        o_r <= o_r + 12'd1;
                    end
                end
                default: begin
                    i_r <= i_r;
                end
            endcase
        end
    end

    // MAC pipeline: stage 1 registers the product, stage 2 accumulates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            last1_r   <= 1'b0;
            o1_r      <= {AADDR_W{1'b0}};
            prod_r    <= {PROD_W{1'b0}};
            run_acc_r <= {ACC_W{1'b0}};
        end else begin
            v1_r <= w_accept_s;
            if (w_accept_s) begin
                prod_r  <= PROD_W'($signed(in_data[DATA_W-1:0])) * PROD_W'(feat_rd_s);
                last1_r <= w_last_s;
                o1_r    <= o_r[AADDR_W-1:0];
            end
            if (state_r == S_IDLE) begin
                run_acc_r <= {ACC_W{1'b0}};
            end else if (v1_r) begin
                run_acc_r <= last1_r ? {ACC_W{1'b0}} : (run_acc_r + prod_ext_s);
            end
        end
    end

    // Single accumulator write port: row result, zero fill or bias update
    always_comb begin
        acc_we_s    = 1'b0;
        acc_waddr_s = {AADDR_W{1'b0}};
        acc_wdata_s = {ACC_W{1'b0}};
        if (v1_r && last1_r) begin
            acc_we_s    = 1'b1;
            acc_waddr_s = o1_r;
            acc_wdata_s = run_acc_r + prod_ext_s;
        end else if (zero_we_s) begin
            acc_we_s    = 1'b1;
            acc_waddr_s = o_r[AADDR_W-1:0];
        end else if (b_accept_s) begin
            acc_we_s    = 1'b1;
            acc_waddr_s = o_r[AADDR_W-1:0];
            acc_wdata_s = acc_rdata_s + bias_ext_s;
        end else begin
            acc_we_s = 1'b0;
        end
    end

    // Feature buffer write
    always_ff @(posedge clk) begin
        if (feat_we_s) begin
            feat_mem[i_r[FADDR_W-1:0]] <= in_data[DATA_W-1:0];
        end
    end

    // Accumulator buffer write
    always_ff @(posedge clk) begin
        if (acc_we_s) begin
            acc_mem[acc_waddr_s] <= acc_wdata_s;
        end
    end

    // Registered result stream and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid_r <= 1'b0;
            dout_data_r  <= {DATA_W{1'b0}};
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            done_r <= (next_state_s == S_DONE);
            busy_r <= (next_state_s != S_IDLE);
            if (out_load_s) begin
                dout_valid_r <= 1'b1;
                dout_data_r  <= sat_s;
            end else if (out_xfer_s) begin
                dout_valid_r <= 1'b0;
            end
        end
    end

    assign fc_dout_valid = dout_valid_r;
    assign fc_dout_data  = dout_data_r;
    assign done          = done_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_fc_mac_core.sv
// Self-checking bench for fc_mac_core: directed fixed-point cases plus
// randomized runs compared against an arithmetic reference model.
module tb_fc_mac_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] cin, cout;
    logic        has_bias, lif_start, lw_start, sof_start, in_valid;
    logic [31:0] in_data;
    logic        fc_dout_valid, fc_dout_ready;
    logic [15:0] fc_dout_data;
    logic        busy, done;

    fc_mac_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cin           (cin),
        .cout          (cout),
        .has_bias      (has_bias),
        .lif_start     (lif_start),
        .lw_start      (lw_start),
        .sof_start     (sof_start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .fc_dout_valid (fc_dout_valid),
        .fc_dout_ready (fc_dout_ready),
        .fc_dout_data  (fc_dout_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    logic [15:0] fv [0:63];
    logic [15:0] wv [0:255];
    logic [15:0] bv [0:63];
    logic [15:0] exp_v [0:63];
    longint      feat_m [0:63];
    longint      acc_m  [0:63];

    // Event monitor: done pulses and completed result transfers
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (fc_dout_valid && fc_dout_ready) xfer_cnt++;
    end

    task automatic check_val(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd16(input int span);
        int v;
        v = int'($urandom_range(0, 2 * span - 1)) - span;
        return v[15:0];
    endfunction

    function automatic logic [15:0] ref_out(input longint a);
        longint s;
        s = a >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[15:0];
    endfunction

    task automatic wait_done(input string tag, input int base, input int budget);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, done_cnt - base, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] w, input int gap);
        logic [31:0] jr;
        jr = $urandom();
        in_valid = 1'b1;
        in_data  = {jr[31:16], w};
        step();
        in_valid = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic do_lif(input int n, input int gap, input int budget);
        int base;
        base = done_cnt;
        cin = 12'(n);
        lif_start = 1'b1;
        step();
        lif_start = 1'b0;
        for (int i = 0; i < n; i++) feed(fv[i], gap);
        for (int i = 0; i < n; i++) feat_m[i] = longint'($signed(fv[i]));
        wait_done($sformatf("lif_done_cin%0d", n), base, budget);
    endtask

    task automatic do_lw(input int ci, input int co, input bit hb, input int gap, input int budget);
        int base;
        longint s;
        base = done_cnt;
        cin = 12'(ci);
        cout = 12'(co);
        has_bias = hb;
        lw_start = 1'b1;
        step();
        lw_start = 1'b0;
        for (int k = 0; k < ci * co; k++) feed(wv[k], gap);
        if (hb) begin
            repeat (3) step();
            for (int o = 0; o < co; o++) feed(bv[o], gap);
        end
        for (int o = 0; o < co; o++) begin
            s = 0;
            for (int i = 0; i < ci; i++) s += longint'($signed(wv[o * ci + i])) * feat_m[i];
            if (hb) s += longint'($signed(bv[o])) * 256;
            acc_m[o] = s;
        end
        wait_done($sformatf("lw_done_%0dx%0d", ci, co), base, budget);
    endtask

    task automatic do_sof(input string tag, input int n, input int hold, input bit inject);
        int base, xb, k;
        logic [15:0] d0;
        bit stable;
        base = done_cnt;
        xb = xfer_cnt;
        sof_start = 1'b1;
        step();
        sof_start = 1'b0;
        for (int j = 0; j < n; j++) begin
            k = 0;
            while (!fc_dout_valid && k < 10) begin
                step();
                k++;
            end
            check_val($sformatf("%s_valid%0d", tag, j), fc_dout_valid, 1);
            d0 = fc_dout_data;
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                sof_start = inject && (j == 1) && (h == 0);
                step();
                sof_start = 1'b0;
                if (fc_dout_data !== d0 || fc_dout_valid !== 1'b1) stable = 1'b0;
            end
            if (hold > 0) check_val($sformatf("%s_stable%0d", tag, j), stable, 1);
            check_val($sformatf("%s_out%0d", tag, j), d0, exp_v[j]);
            fc_dout_ready = 1'b1;
            step();
            fc_dout_ready = 1'b0;
        end
        wait_done($sformatf("%s_done", tag), base, 3);
        check_val($sformatf("%s_xfers", tag), xfer_cnt - xb, n);
    endtask

    task automatic load_exp(input int n);
        for (int o = 0; o < n; o++) exp_v[o] = ref_out(acc_m[o]);
    endtask

    initial begin
        int base_all;
        rst_n = 1'b0;
        cin = 12'd0; cout = 12'd0; has_bias = 1'b0;
        lif_start = 1'b0; lw_start = 1'b0; sof_start = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; fc_dout_ready = 1'b0;
        repeat (3) step();
        check_val("rst_busy", busy, 0);
        check_val("rst_valid", fc_dout_valid, 0);
        check_val("rst_data", fc_dout_data, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        // Identity weights
        base_all = done_cnt;
        fv[0] = 16'h0100; fv[1] = 16'h0200;
        do_lif(2, 1, 6);
        wv[0] = 16'h0100; wv[1] = 16'h0000; wv[2] = 16'h0000; wv[3] = 16'h0100;
        do_lw(2, 2, 1'b0, 1, 6);
        exp_v[0] = 16'h0100; exp_v[1] = 16'h0200;
        do_sof("ident", 2, 0, 1'b0);
        step();
        check_val("ident_done_count", done_cnt - base_all, 3);

        // Bias with negative feature
        fv[0] = 16'hFF00;
        do_lif(1, 1, 6);
        wv[0] = 16'h0300; bv[0] = 16'h0080;
        do_lw(1, 1, 1'b1, 1, 6);
`ifdef FC_RELU_EN
        exp_v[0] = 16'h0000;
`else
        exp_v[0] = 16'hFD80;
`endif
        do_sof("bias", 1, 0, 1'b0);

        // Saturation both directions
        for (int i = 0; i < 4; i++) begin fv[i] = 16'h7FFF; wv[i] = 16'h7FFF; end
        do_lif(4, 1, 6);
        do_lw(4, 1, 1'b0, 1, 6);
        exp_v[0] = 16'h7FFF;
        do_sof("sat_pos", 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) wv[i] = 16'h8001;
        do_lw(4, 1, 1'b0, 1, 6);
`ifdef FC_RELU_EN
        exp_v[0] = 16'h0000;
`else
        exp_v[0] = 16'h8000;
`endif
        do_sof("sat_neg", 1, 0, 1'b0);

        // Random 8x4, back-to-back then every third cycle
        for (int i = 0; i < 8; i++) fv[i] = rnd16(1024);
        for (int k = 0; k < 32; k++) wv[k] = rnd16(1024);
        do_lif(8, 1, 6);
        do_lw(8, 4, 1'b0, 1, 6);
        load_exp(4);
        do_sof("rand_b2b", 4, 0, 1'b0);
        do_lif(8, 3, 6);
        do_lw(8, 4, 1'b0, 3, 6);
        do_sof("rand_gap3", 4, 0, 1'b0);

        // Random with bias, then repeated output under backpressure
        for (int k = 0; k < 32; k++) wv[k] = rnd16(2048);
        for (int o = 0; o < 4; o++) bv[o] = rnd16(8192);
        do_lw(8, 4, 1'b1, 2, 6);
        load_exp(4);
        do_sof("rand_bias", 4, 0, 1'b0);
        do_sof("backpress", 4, 5, 1'b1);

        // Zero-count corners
        do_lif(0, 1, 3);
        do_lw(4, 0, 1'b0, 1, 3);
        do_sof("cout0", 0, 0, 1'b0);
        do_lw(0, 3, 1'b0, 1, 6);
        load_exp(3);
        do_sof("cin0", 3, 0, 1'b0);

        // Reset in the middle of the weight phase, then a full run
        cin = 12'd8; cout = 12'd4; has_bias = 1'b0;
        lw_start = 1'b1;
        step();
        lw_start = 1'b0;
        for (int k = 0; k < 10; k++) feed(rnd16(100), 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_valid", fc_dout_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) fv[i] = rnd16(1024);
        for (int k = 0; k < 32; k++) wv[k] = rnd16(1024);
        for (int o = 0; o < 4; o++) bv[o] = rnd16(4096);
        do_lif(8, 1, 6);
        do_lw(8, 4, 1'b1, 1, 6);
        load_exp(4);
        do_sof("post_rst", 4, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
